cam_array: RTL and testbench

Parametrised content-addressable memory that succeeds the single-cycle CAM decoder. It stores DEPTH entries of WIDTH bits, each with a valid bit. It accepts concurrent read, write, invalidate and search requests, and returns registered read data and a priority-encoded search result one cycle later. It sits between the request front end and the consumer that needs lookup-by-content, such as tag matching or ID translation.

---
 rtl/cam_pkg.sv | 15 +
 rtl/cam_prio_enc.sv | 22 ++
 rtl/cam_array.sv | 134 +++++++++++++
 tb/tb_cam_array.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared constants and result type for the cam_array slice.
package cam_pkg;

  localparam int CAM_WIDTH = 32;
  localparam int CAM_DEPTH = 32;
  // Widest index the result struct can carry; cam_array uses the low ADDR_WIDTH bits.
  localparam int CAM_IDX_W = 16;

  typedef struct packed {
    logic                 match;
    logic                 multi_match;
    logic [CAM_IDX_W-1:0] index;
  } search_result_t;

endpackage

// File: rtl/cam_prio_enc.sv
// Combinational priority encoder over the CAM match vector: any hit, more than one hit,
// and the lowest hitting index.
module cam_prio_enc
  import cam_pkg::*;
#(
  parameter int DEPTH = CAM_DEPTH
) (
  input  logic [DEPTH-1:0] i_match,
  output search_result_t   o_result
);

  // Ascending scan: the first hit fixes the index, any later hit flags multi_match.
  always_comb begin
    o_result = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_result.multi_match = o_result.multi_match | (i_match[i] & o_result.match);
      o_result.index       = (i_match[i] && !o_result.match) ? CAM_IDX_W'(i) : o_result.index;
      o_result.match       = o_result.match | i_match[i];
    end
  end

endmodule

// File: rtl/cam_array.sv
// Parametrised CAM with registered read and priority-encoded search results (latency 1).
// Optional feature macro CAM_MASK_EN adds search_mask_i (1 = ignore bit during search).
module cam_array
  import cam_pkg::*;
#(
  parameter  int WIDTH      = CAM_WIDTH,
  parameter  int DEPTH      = CAM_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  read_enable_i,
  input  logic [ADDR_WIDTH-1:0] read_index_i,
  input  logic                  write_enable_i,
  input  logic                  invalidate_enable_i,
  input  logic [ADDR_WIDTH-1:0] write_index_i,
  input  logic [WIDTH-1:0]      write_data_i,
  input  logic                  search_enable_i,
  input  logic [WIDTH-1:0]      search_data_i,
`ifdef CAM_MASK_EN
  input  logic [WIDTH-1:0]      search_mask_i,
`endif
  output logic                  read_valid_o,
  output logic                  read_hit_o,
  output logic [WIDTH-1:0]      data_o,
  output logic                  search_valid_o,
  output logic                  match_o,
  output logic                  multi_match_o,
  output logic [ADDR_WIDTH-1:0] match_index_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;

  logic             w_wr_in_range;
  logic             w_rd_in_range;
  logic             w_rd_hit;
  logic [WIDTH-1:0] w_rd_data;
  logic [DEPTH-1:0] w_match;
  search_result_t   w_result;
  logic             w_unused_idx;

  logic             r_read_valid;
  logic             r_read_hit;
  logic [WIDTH-1:0] r_data;
  logic             r_search_valid;
  search_result_t   r_result;

  // Indices at or above DEPTH only exist when DEPTH is not a power of two.
  if ((2 ** ADDR_WIDTH) == DEPTH) begin : g_full_range
    assign w_wr_in_range = 1'b1;
    assign w_rd_in_range = 1'b1;
  end else begin : g_partial_range
    assign w_wr_in_range = (write_index_i < ADDR_WIDTH'(DEPTH));
    assign w_rd_in_range = (read_index_i < ADDR_WIDTH'(DEPTH));
  end

  // Data array: deliberately not reset, only loaded by an in-range write.
  always_ff @(posedge clk_i) begin
    if (write_enable_i && w_wr_in_range) begin
      r_mem[write_index_i] <= write_data_i;
    end
  end

  // Valid bits: write sets, invalidate clears, write wins when both are requested.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
    end else if (w_wr_in_range) begin
      if (write_enable_i) begin
        r_valid[write_index_i] <= 1'b1;
      end else if (invalidate_enable_i) begin
        r_valid[write_index_i] <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_match
`ifdef CAM_MASK_EN
    assign w_match[g] = r_valid[g] & ~|((r_mem[g] ^ search_data_i) & ~search_mask_i);
`else
    assign w_match[g] = r_valid[g] & (r_mem[g] == search_data_i);
`endif
  end

  cam_prio_enc #(
    .DEPTH (DEPTH)
  ) u_prio_enc (
    .i_match  (w_match),
    .o_result (w_result)
  );

  // Read lookup: invalid or out-of-range entries read as zero with no hit.
  always_comb begin
    w_rd_hit = w_rd_in_range & r_valid[read_index_i];
    if (w_rd_hit) begin
      w_rd_data = r_mem[read_index_i];
    end else begin
      w_rd_data = '0;
    end
  end

  // Result registers: strobes follow the enables, fields hold between requests.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_read_valid   <= 1'b0;
      r_read_hit     <= 1'b0;
      r_data         <= '0;
      r_search_valid <= 1'b0;
      r_result       <= '0;
    end else begin
      r_read_valid   <= read_enable_i;
      r_search_valid <= search_enable_i;
      if (read_enable_i) begin
        r_read_hit <= w_rd_hit;
        r_data     <= w_rd_data;
      end
      if (search_enable_i) begin
        r_result <= w_result;
      end
    end
  end

  assign w_unused_idx   = ^r_result.index[CAM_IDX_W-1:ADDR_WIDTH];

  assign read_valid_o   = r_read_valid;
  assign read_hit_o     = r_read_hit;
  assign data_o         = r_data;
  assign search_valid_o = r_search_valid;
  assign match_o        = r_result.match;
  assign multi_match_o  = r_result.multi_match;
  assign match_index_o  = r_result.index[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_cam_array.sv
// Self-checking bench for cam_array (DEPTH=20 to exercise out-of-range indices);
// a queue-based model is compared every cycle, plus hand-computed directed checks.
module tb_cam_array;

  localparam int W  = 32;
  localparam int D  = 20;
  localparam int AW = $clog2(D);

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          read_enable_i;
  logic [AW-1:0] read_index_i;
  logic          write_enable_i;
  logic          invalidate_enable_i;
  logic [AW-1:0] write_index_i;
  logic [W-1:0]  write_data_i;
  logic          search_enable_i;
  logic [W-1:0]  search_data_i;
  logic [W-1:0]  search_mask_i;
  logic          read_valid_o;
  logic          read_hit_o;
  logic [W-1:0]  data_o;
  logic          search_valid_o;
  logic          match_o;
  logic          multi_match_o;
  logic [AW-1:0] match_index_o;

  always #5 clk_i = ~clk_i;

  cam_array #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .read_enable_i       (read_enable_i),
    .read_index_i        (read_index_i),
    .write_enable_i      (write_enable_i),
    .invalidate_enable_i (invalidate_enable_i),
    .write_index_i       (write_index_i),
    .write_data_i        (write_data_i),
    .search_enable_i     (search_enable_i),
    .search_data_i       (search_data_i),
`ifdef CAM_MASK_EN
    .search_mask_i       (search_mask_i),
`endif
    .read_valid_o        (read_valid_o),
    .read_hit_o          (read_hit_o),
    .data_o              (data_o),
    .search_valid_o      (search_valid_o),
    .match_o             (match_o),
    .multi_match_o       (multi_match_o),
    .match_index_o       (match_index_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: storage as plain arrays, search as a list of hitting indices.
  logic [W-1:0]  m_mem [D];
  bit            m_valid [D];
  logic          exp_rv, exp_hit, exp_sv, exp_match, exp_multi;
  logic [W-1:0]  exp_data;
  logic [AW-1:0] exp_idx;

  task automatic model_step();
    int           hits[$];
    int           ri;
    int           wi;
    logic [W-1:0] mk;
`ifdef CAM_MASK_EN
    mk = search_mask_i;
`else
    mk = '0;
`endif
    ri = int'(read_index_i);
    wi = int'(write_index_i);
    exp_rv = read_enable_i;
    if (read_enable_i) begin
      exp_hit  = (ri < D) && m_valid[ri];
      exp_data = exp_hit ? m_mem[ri] : '0;
    end
    exp_sv = search_enable_i;
    if (search_enable_i) begin
      for (int i = 0; i < D; i++) begin
        if (m_valid[i] && (((m_mem[i] ^ search_data_i) & ~mk) == '0)) hits.push_back(i);
      end
      exp_match = (hits.size() > 0);
      exp_multi = (hits.size() > 1);
      exp_idx   = (hits.size() > 0) ? AW'(hits[0]) : '0;
    end
    if (write_enable_i && wi < D) begin
      m_mem[wi]   = write_data_i;
      m_valid[wi] = 1'b1;
    end else if (invalidate_enable_i && wi < D) begin
      m_valid[wi] = 1'b0;
    end
  endtask

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < D; i++) m_valid[i] = 1'b0;
      exp_rv = 1'b0; exp_hit = 1'b0; exp_data = '0;
      exp_sv = 1'b0; exp_match = 1'b0; exp_multi = 1'b0; exp_idx = '0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk_i) begin
    if (rst_ni) begin
      chk("m_read_valid", W'(read_valid_o), W'(exp_rv));
      chk("m_read_hit", W'(read_hit_o), W'(exp_hit));
      chk("m_data", data_o, exp_data);
      chk("m_search_valid", W'(search_valid_o), W'(exp_sv));
      chk("m_match", W'(match_o), W'(exp_match));
      chk("m_multi", W'(multi_match_o), W'(exp_multi));
      chk("m_index", W'(match_index_o), W'(exp_idx));
    end
  end

  task automatic idle();
    read_enable_i = 1'b0; read_index_i = '0;
    write_enable_i = 1'b0; invalidate_enable_i = 1'b0; write_index_i = '0; write_data_i = '0;
    search_enable_i = 1'b0; search_data_i = '0; search_mask_i = '0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_write(input int idx, input logic [W-1:0] data);
    idle();
    write_enable_i = 1'b1; write_index_i = AW'(idx); write_data_i = data;
    step();
  endtask

  task automatic do_search_read(input logic [W-1:0] key, input int ridx);
    idle();
    search_enable_i = 1'b1; search_data_i = key;
    read_enable_i = 1'b1; read_index_i = AW'(ridx);
    step();
  endtask

  initial begin
    idle();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_read_valid", W'(read_valid_o), 32'd0);
    chk("rst_search_valid", W'(search_valid_o), 32'd0);
    chk("rst_match", W'(match_o), 32'd0);
    chk("rst_data", data_o, 32'd0);
    rst_ni = 1'b1;

    do_search_read(32'hDEADBEEF, 3);
    chk("empty_sv", W'(search_valid_o), 32'd1);
    chk("empty_match", W'(match_o), 32'd0);
    chk("empty_idx", W'(match_index_o), 32'd0);
    chk("empty_rv", W'(read_valid_o), 32'd1);
    chk("empty_hit", W'(read_hit_o), 32'd0);
    chk("empty_data", data_o, 32'd0);

    do_write(7, 32'hA5A5A5A5);
    chk("strobe_drop_sv", W'(search_valid_o), 32'd0);
    do_search_read(32'hA5A5A5A5, 7);
    chk("rd7_data", data_o, 32'hA5A5A5A5);
    chk("rd7_hit", W'(read_hit_o), 32'd1);
    chk("s7_match", W'(match_o), 32'd1);
    chk("s7_idx", W'(match_index_o), 32'd7);
    chk("s7_multi", W'(multi_match_o), 32'd0);
    idle();
    step();
    chk("hold_sv", W'(search_valid_o), 32'd0);
    chk("hold_idx", W'(match_index_o), 32'd7);
    chk("hold_data", data_o, 32'hA5A5A5A5);

    do_write(4, 32'h1234);
    do_write(9, 32'h1234);
    do_search_read(32'h1234, 9);
    chk("dup_idx", W'(match_index_o), 32'd4);
    chk("dup_multi", W'(multi_match_o), 32'd1);
    idle();
    invalidate_enable_i = 1'b1; write_index_i = AW'(4);
    step();
    do_search_read(32'h1234, 4);
    chk("inv_idx", W'(match_index_o), 32'd9);
    chk("inv_multi", W'(multi_match_o), 32'd0);
    chk("inv_rd_hit", W'(read_hit_o), 32'd0);
    chk("inv_rd_data", data_o, 32'd0);

    idle();
    write_enable_i = 1'b1; write_index_i = AW'(2); write_data_i = 32'h55;
    search_enable_i = 1'b1; search_data_i = 32'h55;
    step();
    chk("nobypass_match", W'(match_o), 32'd0);
    do_search_read(32'h55, 2);
    chk("after_match", W'(match_o), 32'd1);
    chk("after_idx", W'(match_index_o), 32'd2);

    idle();
    write_enable_i = 1'b1; invalidate_enable_i = 1'b1; write_index_i = AW'(5); write_data_i = 32'h77;
    step();
    do_search_read(32'h77, 5);
    chk("wr_inv_hit", W'(read_hit_o), 32'd1);
    chk("wr_inv_data", data_o, 32'h77);

    do_write(25, 32'h1234);
    do_search_read(32'h1234, 25);
    chk("oor_idx", W'(match_index_o), 32'd9);
    chk("oor_multi", W'(multi_match_o), 32'd0);
    chk("oor_rd_hit", W'(read_hit_o), 32'd0);
    do_write(19, 32'hCAFE);
    do_search_read(32'hCAFE, 19);
    chk("last_hit", W'(read_hit_o), 32'd1);
    chk("last_idx", W'(match_index_o), 32'd19);
    do_search_read(32'hCAFE, 20);
    chk("rd20_hit", W'(read_hit_o), 32'd0);

`ifdef CAM_MASK_EN
    do_write(0, 32'h12345678);
    idle();
    search_enable_i = 1'b1; search_data_i = 32'h12340000; search_mask_i = 32'h0000FFFF;
    step();
    chk("mask_match", W'(match_o), 32'd1);
    chk("mask_idx", W'(match_index_o), 32'd0);
    idle();
    search_enable_i = 1'b1; search_data_i = 32'h12340000; search_mask_i = 32'h0;
    step();
    chk("nomask_match", W'(match_o), 32'd0);
    idle();
    search_enable_i = 1'b1; search_data_i = 32'h0; search_mask_i = 32'hFFFFFFFF;
    step();
    chk("allmask_idx", W'(match_index_o), 32'd0);
    chk("allmask_multi", W'(multi_match_o), 32'd1);
`endif

    // Back-to-back mixed traffic, checked by the per-cycle model comparison.
    for (int i = 0; i < 40; i++) begin
      idle();
      write_enable_i      = (i % 3 == 0);
      invalidate_enable_i = (i % 4 == 1);
      write_index_i       = AW'((i * 7) % 24);
      write_data_i        = W'(i % 5);
      search_enable_i     = (i % 2 == 0) || (i % 5 == 3);
      search_data_i       = W'((i + 1) % 5);
      read_enable_i       = (i % 3 != 2);
      read_index_i        = AW'((i * 3) % 24);
      step();
    end

    do_write(5, 32'h77);
    do_search_read(32'h77, 5);
    chk("pre_rst_match", W'(match_o), 32'd1);
    chk("pre_rst_idx", W'(match_index_o), 32'd5);
    do_search_read(32'h77, 5);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("midrst_sv", W'(search_valid_o), 32'd0);
    chk("midrst_rv", W'(read_valid_o), 32'd0);
    chk("midrst_match", W'(match_o), 32'd0);
    idle();
    step();
    rst_ni = 1'b1;
    do_search_read(32'h77, 5);
    chk("postrst_match", W'(match_o), 32'd0);
    chk("postrst_hit", W'(read_hit_o), 32'd0);
    do_search_read(32'hCAFE, 19);
    chk("postrst_match19", W'(match_o), 32'd0);

    idle();
    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
